// File: rtl/key_repeat_pkg.sv
// Shared constants for the clock key conditioner:
// key indices, channel FSM encodings and 50 MHz timing defaults.
package key_repeat_pkg;

  localparam logic [1:0] KEY_MIN  = 2'd0;
  localparam logic [1:0] KEY_HOUR = 2'd1;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRESS_DB   = 3'd1;
  localparam logic [2:0] ST_PRESSED    = 3'd2;
  localparam logic [2:0] ST_REPEAT     = 3'd3;
  localparam logic [2:0] ST_RELEASE_DB = 3'd4;

  localparam int DEF_DEBOUNCE_CYC = 1000000;
  localparam int DEF_HOLD_CYC     = 25000000;
  localparam int DEF_REPEAT_CYC   = 10000000;
  localparam int DEF_CNT_W        = 25;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce, press pulse
// and auto-repeat while held.
module key_channel
  import key_repeat_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic clr,
  input  logic i_key,
  output logic o_pulse,
  output logic o_level,
  output logic o_held
);

  logic             r_s1;
  logic             r_s2;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_level;
  logic             r_held;

  logic             w_db_done;
  logic             w_hold_done;
  logic             w_rep_done;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_db_done   = (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));
  assign w_hold_done = (r_cnt == CNT_W'(HOLD_CYC - 1));
  assign w_rep_done  = (r_cnt == CNT_W'(REPEAT_CYC - 1));
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  // Release (s2 low) is tested first so it wins over any timer expiry.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_s1    <= i_key;
      r_s2    <= r_s1;
      r_pulse <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (r_s2) begin
            r_state <= ST_PRESS_DB;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_DB: begin
          if (!r_s2) begin
            r_state <= ST_IDLE;
          end else if (w_db_done) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
            r_pulse <= 1'b1;
            r_level <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!r_s2) begin
            r_state <= ST_RELEASE_DB;
            r_cnt   <= '0;
          end else if (w_hold_done) begin
            r_state <= ST_REPEAT;
            r_cnt   <= '0;
            r_pulse <= 1'b1;
            r_held  <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_REPEAT: begin
          if (!r_s2) begin
            r_state <= ST_RELEASE_DB;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end else if (w_rep_done) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_RELEASE_DB: begin
          if (r_s2) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
          end else if (w_db_done) begin
            r_state <= ST_IDLE;
            r_level <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pulse = r_pulse;
  assign o_level = r_level;
  assign o_held  = r_held;

endmodule

// File: rtl/key_repeat.sv
// Conditions the raw set buttons for the clock core:
// one independent key_channel per key.
module key_repeat
  import key_repeat_pkg::*;
#(
  parameter int NUM_KEYS     = 2,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_held
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .HOLD_CYC     (HOLD_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk     (clk),
      .clr     (clr),
      .i_key   (key_in[g]),
      .o_pulse (key_pulse[g]),
      .o_level (key_level[g]),
      .o_held  (key_held[g])
    );
  end

endmodule

// File: tb/tb_key_repeat.sv
// Directed bench for key_repeat with short timing
// (debounce 4, hold 10, repeat 3).
module tb_key_repeat;

  logic       clk;
  logic       clr;
  logic [1:0] key_in;
  logic [1:0] key_pulse;
  logic [1:0] key_level;
  logic [1:0] key_held;

  int n_tests;
  int n_fail;

  key_repeat #(
    .NUM_KEYS     (2),
    .DEBOUNCE_CYC (4),
    .HOLD_CYC     (10),
    .REPEAT_CYC   (3),
    .CNT_W        (25)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .key_in    (key_in),
    .key_pulse (key_pulse),
    .key_level (key_level),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive k for the next rising edge, then sample just after it.
  task automatic step(input logic [1:0] k);
    key_in = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00);
  endtask

  task automatic test_reset();
    logic [5:0] exp_v;
    logic [5:0] got_v;
    clr = 1'b1;
    step(2'b00);
    step(2'b00);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) step(2'b11);
    // mid-press reset with both keys held
    for (int e = 0; e <= 12; e++) begin
      clr = (e < 2);
      step(2'b11);
      exp_v = {(e == 8) ? 2'b11 : 2'b00,
               (e >= 8) ? 2'b11 : 2'b00,
               2'b00};
      got_v = {key_pulse, key_level, key_held};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset e=%0d got %b exp %b",
                 e, got_v, exp_v);
      end
    end
    clr = 1'b0;
    idle(20);
  endtask

  task automatic test_clean();
    logic [5:0] exp_v;
    logic [5:0] got_v;
    for (int e = 0; e <= 20; e++) begin
      step((e <= 7) ? 2'b01 : 2'b00);
      exp_v = {1'b0, (e == 6),
               1'b0, (e >= 6 && e <= 13),
               2'b00};
      got_v = {key_pulse, key_level, key_held};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL clean e=%0d got %b exp %b",
                 e, got_v, exp_v);
      end
    end
    idle(10);
  endtask

  task automatic test_glitch();
    logic [5:0] got_v;
    for (int e = 0; e <= 15; e++) begin
      step((e <= 2) ? 2'b01 : 2'b00);
      got_v = {key_pulse, key_level, key_held};
      n_tests++;
      if (got_v !== 6'b0) begin
        n_fail++;
        $display("FAIL glitch e=%0d got %b exp %b",
                 e, got_v, 6'b0);
      end
    end
    idle(5);
  endtask

  task automatic test_hold();
    logic [2:0] exp_v;
    logic [2:0] got_v;
    int npulse;
    npulse = 0;
    for (int e = 0; e <= 40; e++) begin
      step((e <= 29) ? 2'b01 : 2'b00);
      exp_v[2] = (e == 6) ||
                 (e >= 16 && e <= 31 && (e - 16) % 3 == 0);
      exp_v[1] = (e >= 16 && e <= 31);
      exp_v[0] = (e >= 6 && e <= 35);
      got_v = {key_pulse[0], key_held[0], key_level[0]};
      if (key_pulse[0] === 1'b1) npulse++;
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL hold e=%0d got %b exp %b",
                 e, got_v, exp_v);
      end
    end
    n_tests++;
    if (npulse !== 7) begin
      n_fail++;
      $display("FAIL hold_count got %0d exp 7", npulse);
    end
    idle(10);
  endtask

  task automatic test_release_bounce();
    logic [2:0] exp_v;
    logic [2:0] got_v;
    for (int e = 0; e <= 23; e++) begin
      step((e <= 6 || e >= 9) ? 2'b01 : 2'b00);
      exp_v[2] = (e == 6 || e == 21);
      exp_v[1] = (e >= 21);
      exp_v[0] = (e >= 6);
      got_v = {key_pulse[0], key_held[0], key_level[0]};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL bounce e=%0d got %b exp %b",
                 e, got_v, exp_v);
      end
    end
    idle(15);
  endtask

  task automatic test_independence();
    logic [1:0] exp_p;
    logic [1:0] k;
    for (int e = 0; e <= 18; e++) begin
      k[0] = 1'b1;
      k[1] = (e >= 3);
      step(k);
      exp_p[0] = (e == 6 || e == 16);
      exp_p[1] = (e == 9);
      n_tests++;
      if (key_pulse !== exp_p) begin
        n_fail++;
        $display("FAIL indep e=%0d got %b exp %b",
                 e, key_pulse, exp_p);
      end
    end
    idle(15);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr     = 1'b0;
    key_in  = 2'b00;
    test_reset();
    test_clean();
    test_glitch();
    test_hold();
    test_release_bounce();
    test_independence();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_repeat.md
Name: key_repeat

Overview:
- Conditions the raw push-button inputs (hour-set, minute-set) before they reach the digital clock core.
- Per key: 2-flop synchronizer, then debounce, then a single-cycle press pulse, then auto-repeat pulses while the key is held.
- Replaces the clock core's direct sampling of raw seth/setm levels. The core advances one step per key_pulse.

Parameters:
- NUM_KEYS, 2, number of independent key channels (bit 0 = minute-set, bit 1 = hour-set).
- DEBOUNCE_CYC, 1000000, cycles a synchronized level must hold stable to be accepted (20 ms at 50 MHz).
- HOLD_CYC, 25000000, cycles from the press pulse to the first repeat pulse (0.5 s).
- REPEAT_CYC, 10000000, cycles between repeat pulses (0.2 s).
- CNT_W, 25, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYC, HOLD_CYC, REPEAT_CYC).

Ports:
- clk  in  1  system clock (50 MHz).
- clr  in  1  synchronous active-high reset.
- key_in  in  NUM_KEYS  raw asynchronous button levels, 1 = pressed.
- key_pulse  out  NUM_KEYS  one-cycle step strobe per key (press or repeat).
- key_level  out  NUM_KEYS  debounced key level.
- key_held  out  NUM_KEYS  high while the key is in auto-repeat.

Behaviour:
- Reset: one clock with a single rising clk edge and synchronous active-high reset clr; reset is sampled only on clk rising edges.
  - While clr=1 at an edge: all synchronizer flops, counters and outputs clear to 0, and every FSM goes to IDLE.
  - Reset mid-press: the channel returns to IDLE. A still-pressed key is re-debounced and produces a fresh press pulse.
- Synchronizer: s1 <= key_in; s2 <= s1. The FSM uses s2 only.
- Per-channel FSM (states: IDLE, PRESS_DB, PRESSED, REPEAT, RELEASE_DB), with counter cnt:
  - IDLE: when s2=1, go to PRESS_DB with cnt=0.
  - PRESS_DB:
    - s2=0: back to IDLE (glitch rejected, no pulse).
    - s2=1 and cnt==DEBOUNCE_CYC-1: go to PRESSED, cnt=0, key_pulse=1, key_level=1.
    - Otherwise cnt++.
  - PRESSED:
    - s2=0: go to RELEASE_DB with cnt=0.
    - cnt==HOLD_CYC-1: go to REPEAT, cnt=0, key_pulse=1, key_held=1.
    - Otherwise cnt++.
  - REPEAT:
    - s2=0: go to RELEASE_DB with cnt=0; key_held drops at this edge.
    - cnt==REPEAT_CYC-1: key_pulse=1 and cnt=0.
    - Otherwise cnt++.
  - RELEASE_DB:
    - s2=1: go to PRESSED with cnt=0 (bounce rejected, no pulse; the hold timer restarts).
    - cnt==DEBOUNCE_CYC-1: go to IDLE, key_level=0.
    - Otherwise cnt++.
    - Never emits key_pulse.
- Release has priority over any timer expiry in the same cycle.
- key_pulse is registered and high for exactly one cycle per event. It is never high on two consecutive cycles unless REPEAT_CYC==1.
- Latency: the first edge sampling key_in=1 is edge 0. The press pulse registers at edge DEBOUNCE_CYC+2. The first repeat comes HOLD_CYC edges later, then one every REPEAT_CYC edges.
- Channels are fully independent. Simultaneous presses yield simultaneous pulses; prioritising them is the core's job.
- Counters saturate logically via the compare; no wrap-around is reachable given the CNT_W constraint.

Decomposition:
- Shared clock package holds:
  - the 2-bit key-index constants (KEY_MIN=0, KEY_HOUR=1);
  - the FSM state enum (3-bit encoding: IDLE=0, PRESS_DB=1, PRESSED=2, REPEAT=3, RELEASE_DB=4);
  - the 50 MHz timing defaults.
- One sub-module, key_channel: synchronizer, FSM and counter for a single key. key_repeat instantiates NUM_KEYS copies via generate.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, HOLD_CYC=10, REPEAT_CYC=3; edge 0 is the first edge sampling key_in=1.
- Reset: assert clr for 2 cycles with key_in=2'b11 -> all outputs 0. After release, key_pulse[0] and key_pulse[1] rise together at edge 8 (clr deasserted at edge 2).
- Clean press: key_in[0]=1 for edges 0..7, then 0 -> single key_pulse[0] at edge 6. key_level[0] is 1 from edge 6 until edge 13 (back to 0 after RELEASE_DB completes). No other pulses.
- Glitch: key_in[0]=1 for edges 0..2 only -> no key_pulse and key_level stays 0.
- Hold: key_in[0]=1 for edges 0..29 -> pulses at edges 6, 16, 19, 22, 25, 28, 31 (7 total). key_held[0] is high from edge 16 through edge 31 and drops at edge 32.
- Release bounce: after the edge-6 pulse, key_in[0]=0 for 2 edges then 1 again -> no extra pulse. key_level stays 1, and the first repeat arrives 10 edges after s2 returns high.
- Independence: key_in[1] pressed 3 cycles after key_in[0] -> key_pulse[1] at edge 9, key_pulse[0] timing unchanged.
